// File: rtl/clic_irq_ctrl.sv
// Minimal CLIC-style interrupt controller: per-line pending/enable/attr/level state,
// level+ID arbitration against a threshold, registered winner, and a word config port.
module clic_irq_ctrl #(
  parameter int NumInterrupts = 64,
  parameter int IdWidth       = $clog2(NumInterrupts),
  parameter int CfgAddrWidth  = 16
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NumInterrupts-1:0] irq_src_i,
  output logic [NumInterrupts-1:0] irq_o,
  output logic [7:0]               irq_level_o,
  output logic                     irq_shv_o,
  output logic [1:0]               irq_priv_o,
  input  logic [IdWidth-1:0]       irq_id_i,
  input  logic                     irq_ack_i,
  input  logic                     cfg_req_i,
  input  logic                     cfg_we_i,
  input  logic [CfgAddrWidth-1:0]  cfg_addr_i,
  input  logic [31:0]              cfg_wdata_i,
  input  logic [3:0]               cfg_be_i,
  output logic [31:0]              cfg_rdata_o,
  output logic                     cfg_rvalid_o,
  output logic                     cfg_err_o
);

  logic [NumInterrupts-1:0] src_q, ip, ie, trig, shv;
  logic [1:0]               priv [NumInterrupts];
  logic [7:0]               ctl  [NumInterrupts];
  logic [7:0]               mintthresh;

  // Address decode: 0x0000 is the threshold, 0x1000.. is one word per line.
  logic [31:0]        addr_ext, line_off, rd_word;
  logic               thresh_hit, line_hit;
  logic [IdWidth-1:0] line_idx;

  assign addr_ext   = 32'(cfg_addr_i);
  assign line_off   = addr_ext - 32'h1000;
  assign thresh_hit = (addr_ext == 32'h0);
  assign line_hit   = (addr_ext >= 32'h1000) && (line_off < 32'(4 * NumInterrupts))
                      && (addr_ext[1:0] == 2'b00);
  assign line_idx   = line_off[IdWidth+1:2];
  assign rd_word    = {ctl[line_idx], priv[line_idx], 4'b0000, trig[line_idx], shv[line_idx],
                       7'b0, ie[line_idx], 7'b0, ip[line_idx]};

  logic unused_wdata;
  assign unused_wdata = ^{cfg_wdata_i[15:9], cfg_wdata_i[21:18]};

  logic [NumInterrupts-1:0] ack_sel, wr_sel, cand;

  always_comb begin
    ack_sel = '0;
    wr_sel  = '0;
    cand    = '0;
    for (int i = 0; i < NumInterrupts; i++) begin
      ack_sel[i] = irq_ack_i && (irq_id_i == IdWidth'(i));
      wr_sel[i]  = cfg_req_i && cfg_we_i && line_hit && (line_idx == IdWidth'(i));
      // The line just acknowledged sits out one arbitration so it is not re-presented stale.
      cand[i]    = ip[i] && ie[i] && (ctl[i] > mintthresh) && !ack_sel[i];
    end
  end

  logic               win_found;
  logic [IdWidth-1:0] win_id;
  logic [7:0]         win_lvl;

  // Ascending scan with >= lets the higher ID win ties.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    win_lvl   = '0;
    for (int i = 0; i < NumInterrupts; i++) begin
      if (cand[i] && (!win_found || ctl[i] >= win_lvl)) begin
        win_found = 1'b1;
        win_id    = IdWidth'(i);
        win_lvl   = ctl[i];
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      src_q        <= '0;
      ip           <= '0;
      ie           <= '0;
      trig         <= '0;
      shv          <= '0;
      mintthresh   <= '0;
      for (int i = 0; i < NumInterrupts; i++) begin
        priv[i] <= 2'b11;
        ctl[i]  <= '0;
      end
      irq_o        <= '0;
      irq_level_o  <= '0;
      irq_shv_o    <= 1'b0;
      irq_priv_o   <= '0;
      cfg_rdata_o  <= '0;
      cfg_rvalid_o <= 1'b0;
      cfg_err_o    <= 1'b0;
    end else begin
      src_q <= irq_src_i;
      for (int i = 0; i < NumInterrupts; i++) begin
        // Edge lines: hardware set beats ack clear beats software write.
        if (!trig[i])                          ip[i] <= irq_src_i[i];
        else if (irq_src_i[i] && !src_q[i])    ip[i] <= 1'b1;
        else if (ack_sel[i])                   ip[i] <= 1'b0;
        else if (wr_sel[i] && cfg_be_i[0])     ip[i] <= cfg_wdata_i[0];
        if (wr_sel[i]) begin
          if (cfg_be_i[1]) ie[i] <= cfg_wdata_i[8];
          if (cfg_be_i[2]) begin
            priv[i] <= cfg_wdata_i[23:22];
            trig[i] <= cfg_wdata_i[17];
            shv[i]  <= cfg_wdata_i[16];
          end
          if (cfg_be_i[3]) ctl[i] <= cfg_wdata_i[31:24];
        end
      end
      if (cfg_req_i && cfg_we_i && thresh_hit && cfg_be_i[0])
        mintthresh <= cfg_wdata_i[7:0];

      cfg_rvalid_o <= cfg_req_i;
      cfg_err_o    <= cfg_req_i && !(thresh_hit || line_hit);
      if (cfg_req_i && !cfg_we_i && thresh_hit)    cfg_rdata_o <= {24'b0, mintthresh};
      else if (cfg_req_i && !cfg_we_i && line_hit) cfg_rdata_o <= rd_word;
      else                                         cfg_rdata_o <= '0;

      irq_o       <= win_found ? (NumInterrupts'(1) << win_id) : '0;
      irq_level_o <= win_found ? win_lvl : 8'h00;
      irq_shv_o   <= win_found ? shv[win_id] : 1'b0;
      irq_priv_o  <= win_found ? priv[win_id] : 2'b00;
    end
  end

endmodule

// File: tb/tb_clic_irq_ctrl.sv
// Directed bench for clic_irq_ctrl: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares irq outputs and config responses.
module tb_clic_irq_ctrl;
  localparam int N  = 64;
  localparam int IW = 6;
  localparam int AW = 16;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [N-1:0]  irq_src, irq;
  logic [7:0]    irq_level;
  logic          irq_shv;
  logic [1:0]    irq_priv;
  logic [IW-1:0] irq_id;
  logic          irq_ack;
  logic          cfg_req, cfg_we;
  logic [AW-1:0] cfg_addr;
  logic [31:0]   cfg_wdata, cfg_rdata;
  logic [3:0]    cfg_be;
  logic          cfg_rvalid, cfg_err;

  clic_irq_ctrl #(.NumInterrupts(N), .IdWidth(IW), .CfgAddrWidth(AW)) dut (
    .clk_i(clk), .rst_ni(rst_n), .irq_src_i(irq_src),
    .irq_o(irq), .irq_level_o(irq_level), .irq_shv_o(irq_shv), .irq_priv_o(irq_priv),
    .irq_id_i(irq_id), .irq_ack_i(irq_ack),
    .cfg_req_i(cfg_req), .cfg_we_i(cfg_we), .cfg_addr_i(cfg_addr),
    .cfg_wdata_i(cfg_wdata), .cfg_be_i(cfg_be),
    .cfg_rdata_o(cfg_rdata), .cfg_rvalid_o(cfg_rvalid), .cfg_err_o(cfg_err)
  );

  // scoreboard
  typedef struct {
    int           due;
    logic [N-1:0] irq;
    logic [7:0]   lvl;
    logic         shv;
    logic [1:0]   priv;
  } irq_exp_t;
  irq_exp_t    irq_q[$];
  logic [32:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // driver tasks
  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic expect_irq(input int delay, input int id, input logic [7:0] lvl,
                            input logic shv, input logic [1:0] priv);
    irq_exp_t e;
    e.due  = cyc + delay;
    e.irq  = (id < 0) ? '0 : (N'(1) << id);
    e.lvl  = lvl;
    e.shv  = shv;
    e.priv = priv;
    irq_q.push_back(e);
  endtask

  task automatic expect_none(input int delay);
    expect_irq(delay, -1, 8'h00, 1'b0, 2'b00);
  endtask

  task automatic cfg_access(input logic we, input logic [AW-1:0] addr, input logic [31:0] wdata,
                            input logic [3:0] be, input logic err, input logic [31:0] rdata);
    cfg_req = 1'b1; cfg_we = we; cfg_addr = addr; cfg_wdata = wdata; cfg_be = be;
    exp_q.push_back({err, rdata});
    tick(1);
    cfg_req = 1'b0; cfg_we = 1'b0;
  endtask

  task automatic cfg_wr(input logic [AW-1:0] addr, input logic [31:0] wdata, input logic [3:0] be);
    cfg_access(1'b1, addr, wdata, be, 1'b0, 32'h0);
  endtask

  task automatic cfg_rd(input logic [AW-1:0] addr, input logic [31:0] rdata);
    cfg_access(1'b0, addr, 32'h0, 4'h0, 1'b0, rdata);
  endtask

  function automatic logic [AW-1:0] line_addr(input int i);
    return 16'h1000 + 16'(4 * i);
  endfunction

  // monitor
  irq_exp_t    m_e;
  logic [32:0] m_c;
  always @(negedge clk) begin
    if (cfg_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cfg_resp unexpected cyc=%0d err=%b rdata=%h", cyc, cfg_err, cfg_rdata);
      end else begin
        m_c = exp_q.pop_front();
        if ({cfg_err, cfg_rdata} !== m_c) begin
          errors++;
          $display("FAIL cfg_resp cyc=%0d got err=%b rdata=%h want err=%b rdata=%h",
                   cyc, cfg_err, cfg_rdata, m_c[32], m_c[31:0]);
        end
      end
    end
    while (irq_q.size() > 0 && irq_q[0].due <= cyc) begin
      m_e = irq_q.pop_front();
      checks++;
      if (m_e.due < cyc) begin
        errors++;
        $display("FAIL irq_out missed check due=%0d cyc=%0d", m_e.due, cyc);
      end else if ({irq, irq_level, irq_shv, irq_priv} !== {m_e.irq, m_e.lvl, m_e.shv, m_e.priv}) begin
        errors++;
        $display("FAIL irq_out cyc=%0d got irq=%h lvl=%h shv=%b priv=%b want irq=%h lvl=%h shv=%b priv=%b",
                 cyc, irq, irq_level, irq_shv, irq_priv, m_e.irq, m_e.lvl, m_e.shv, m_e.priv);
      end
    end
  end

  // stimulus
  initial begin
    rst_n = 1'b0; irq_src = '0; irq_id = '0; irq_ack = 1'b0;
    cfg_req = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_wdata = '0; cfg_be = '0;
    tick(2);
    expect_none(0);
    rst_n = 1'b1;
    expect_none(1);
    cfg_rd(16'h0000, 32'h0);
    cfg_rd(line_addr(63), 32'h00C0_0000);
    cfg_rd(line_addr(0), 32'h00C0_0000);

    // edge line 5: present, ack clears
    cfg_wr(line_addr(5), 32'h40C2_0100, 4'b1110);
    irq_src[5] = 1'b1; expect_irq(2, 5, 8'h40, 1'b0, 2'b11); tick(1);
    irq_src[5] = 1'b0; tick(1);
    irq_ack = 1'b1; irq_id = 5; expect_none(1); expect_none(3); tick(1);
    irq_ack = 1'b0; tick(3);
    cfg_rd(line_addr(5), 32'h40C2_0100);

    // equal levels 3 and 9: higher ID first
    cfg_wr(line_addr(3), 32'h80C2_0100, 4'b1110);
    cfg_wr(line_addr(9), 32'h80C2_0100, 4'b1110);
    irq_src[3] = 1'b1; irq_src[9] = 1'b1; expect_irq(2, 9, 8'h80, 1'b0, 2'b11); tick(1);
    irq_src[3] = 1'b0; irq_src[9] = 1'b0; tick(1);
    irq_ack = 1'b1; irq_id = 9; expect_irq(1, 3, 8'h80, 1'b0, 2'b11); tick(1);
    irq_id = 3; expect_none(1); expect_none(2); tick(1);
    irq_ack = 1'b0; tick(2);

    // level line 7: ack masks one cycle, then re-presented
    cfg_wr(line_addr(7), 32'h20C0_0100, 4'b1110);
    irq_src[7] = 1'b1; expect_irq(2, 7, 8'h20, 1'b0, 2'b11); tick(2);
    irq_ack = 1'b1; irq_id = 7; expect_none(1); expect_irq(2, 7, 8'h20, 1'b0, 2'b11); tick(1);
    irq_ack = 1'b0; tick(1);
    irq_src[7] = 1'b0; expect_irq(1, 7, 8'h20, 1'b0, 2'b11); expect_none(2); tick(3);

    // threshold: ctl == mintthresh blocks, one below admits
    cfg_wr(16'h0000, 32'h0000_0050, 4'b0001);
    cfg_wr(line_addr(2), 32'h50C2_0100, 4'b1110);
    irq_src[2] = 1'b1; expect_none(2); expect_none(3); tick(1);
    irq_src[2] = 1'b0; tick(2);
    expect_irq(2, 2, 8'h50, 1'b0, 2'b11);
    cfg_wr(16'h0000, 32'h0000_004F, 4'b0001);
    cfg_rd(16'h0000, 32'h0000_004F);
    irq_ack = 1'b1; irq_id = 2; expect_none(1); expect_none(2); tick(1);
    irq_ack = 1'b0; tick(2);
    cfg_wr(16'h0000, 32'hFFFF_FF00, 4'b1111);
    cfg_rd(16'h0000, 32'h0);

    // edge line 4 with shv: edge during own ack wins
    cfg_wr(line_addr(4), 32'h30C3_0100, 4'b1110);
    irq_src[4] = 1'b1; expect_irq(2, 4, 8'h30, 1'b1, 2'b11); tick(1);
    irq_src[4] = 1'b0; tick(1);
    irq_src[4] = 1'b1; irq_ack = 1'b1; irq_id = 4;
    expect_none(1); expect_irq(2, 4, 8'h30, 1'b1, 2'b11); tick(1);
    irq_ack = 1'b0; tick(1);
    irq_ack = 1'b1; irq_id = 4; expect_none(1); expect_none(2); tick(1);
    irq_ack = 1'b0; irq_src[4] = 1'b0; tick(2);
    // software set of an edge line presents it; level lines ignore it
    expect_irq(2, 4, 8'h30, 1'b1, 2'b11);
    cfg_wr(line_addr(4), 32'h0000_0001, 4'b0001); tick(1);
    irq_ack = 1'b1; irq_id = 4; expect_none(1); expect_none(2); tick(1);
    irq_ack = 1'b0; tick(2);
    cfg_rd(line_addr(4), 32'h30C3_0100);
    expect_none(2);
    cfg_wr(line_addr(7), 32'h0000_0001, 4'b0001); tick(2);

    // unmapped accesses and mid-operation reset
    cfg_rd(line_addr(63), 32'h00C0_0000);
    cfg_access(1'b0, 16'h0800, 32'h0, 4'h0, 1'b1, 32'h0);
    cfg_access(1'b0, 16'h1100, 32'h0, 4'h0, 1'b1, 32'h0);
    cfg_access(1'b1, 16'h0004, 32'hFFFF_FFFF, 4'hF, 1'b1, 32'h0);
    cfg_rd(16'h0000, 32'h0);
    expect_irq(2, 5, 8'h40, 1'b0, 2'b11);
    cfg_wr(line_addr(5), 32'h0000_0001, 4'b0001); tick(1);
    rst_n = 1'b0; expect_none(1); tick(1);
    rst_n = 1'b1; expect_none(2); tick(2);
    cfg_rd(line_addr(5), 32'h00C0_0000);
    tick(3);

    // final report
    checks++;
    if (irq_q.size() != 0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover expectations irq=%0d cfg=%0d want 0", irq_q.size(), exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
